// File: rtl/mem_request_sequencer.sv
// rtl/mem_request_sequencer.sv - request FIFO feeding a single-outstanding memory issue FSM
// Requests are queued, issued one at a time as held enables, and answered with data or a timeout error.
module mem_request_sequencer #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDRESS_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_write,
  output logic                          resp_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          mem_read_enable,
  output logic                          mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0]      mem_address,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  output logic                          mem_data_oe,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic                          mem_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_write;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [TMO_W-1:0]         timer;
  logic                     cur_write;
  logic                     push;
  logic                     pop;

  // Ready depends on occupancy only, so a full FIFO never accepts even while popping.
  assign req_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_data[wr_ptr]  <= req_wdata;
      fifo_write[wr_ptr] <= req_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      timer            <= '0;
      cur_write        <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_data_oe      <= 1'b0;
      mem_address      <= '0;
      mem_data_out     <= '0;
      resp_valid       <= 1'b0;
      resp_write       <= 1'b0;
      resp_error       <= 1'b0;
      resp_rdata       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            mem_address      <= fifo_addr[rd_ptr];
            mem_data_out     <= fifo_data[rd_ptr];
            cur_write        <= fifo_write[rd_ptr];
            mem_write_enable <= fifo_write[rd_ptr];
            mem_read_enable  <= !fifo_write[rd_ptr];
            mem_data_oe      <= fifo_write[rd_ptr];
            timer            <= '0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          // A done pulse on the final timeout cycle still completes normally.
          if (mem_done || timer == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_data_oe      <= 1'b0;
            resp_valid       <= 1'b1;
            resp_write       <= cur_write;
            resp_error       <= !mem_done;
            resp_rdata       <= (mem_done && !cur_write) ? mem_data_in : '0;
            state            <= RESP;
          end else begin
            timer <= timer + TMO_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb/tb_mem_request_sequencer.sv - vector, directed and randomized checks of mem_request_sequencer
module tb_mem_request_sequencer;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int NRAND = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_write, resp_error;
  logic [DW-1:0] resp_rdata;
  logic [2:0]    fifo_count;
  logic          mem_read_enable, mem_write_enable, mem_data_oe, mem_done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in;

  mem_request_sequencer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .resp_error(resp_error), .fifo_count(fifo_count),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_oe(mem_data_oe),
    .mem_data_in(mem_data_in), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] bus;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} req_t;
  typedef struct packed {logic w; logic err; logic [31:0] rd;} rsp_t;

  vec_t        vecs [7];
  req_t        exp_req [$];
  rsp_t        exp_rsp [$];
  logic [31:0] mem_model [16];
  int          sent, served, received;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic en();
    return mem_read_enable || mem_write_enable;
  endfunction

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int cyc;
    int oe_cyc;
    push(v.w, v.addr, v.wdata);
    check($sformatf("v%0d_no_early_issue", i), en(), 0);
    tick();
    check($sformatf("v%0d_wr_en", i), mem_write_enable, v.w);
    check($sformatf("v%0d_rd_en", i), mem_read_enable, !v.w);
    check($sformatf("v%0d_addr", i), mem_address, v.addr);
    if (v.w) check($sformatf("v%0d_wdata", i), mem_data_out, v.wdata);
    cyc = 0;
    oe_cyc = 0;
    for (int k = 0; k < 20 && en(); k++) begin
      cyc++;
      if (mem_data_oe) oe_cyc++;
      mem_done    = (cyc == v.dly);
      mem_data_in = (cyc == v.dly) ? v.bus : ~v.bus;
      tick();
    end
    mem_done = 1'b0;
    mem_data_in = ~v.bus;
    check($sformatf("v%0d_enable_cycles", i), cyc, v.exp_cyc);
    check($sformatf("v%0d_oe_cycles", i), oe_cyc, v.w ? v.exp_cyc : 0);
    check($sformatf("v%0d_resp_valid", i), resp_valid, 1);
    check($sformatf("v%0d_resp_write", i), resp_write, v.w);
    check($sformatf("v%0d_resp_error", i), resp_error, v.exp_err);
    check($sformatf("v%0d_resp_rdata", i), resp_rdata, v.exp_rdata);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check($sformatf("v%0d_resp_cleared", i), resp_valid, 0);
  endtask

  task automatic serve_read(input string nm, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    while (!en() && k < 30) begin
      tick();
      k++;
    end
    check({nm, "_issue"}, mem_read_enable, 1);
    check({nm, "_addr"}, mem_address, a);
    mem_done = 1'b1;
    mem_data_in = d;
    tick();
    mem_done = 1'b0;
    mem_data_in = '0;
    check({nm, "_valid"}, resp_valid, 1);
    check({nm, "_rdata"}, resp_rdata, d);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_done = 1'b0; mem_data_in = '0;

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0,        1'b0, 32'h0,        3};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3};
    vecs[2] = '{1'b0, 32'h20, 32'h0,        0, 32'h12345678, 1'b1, 32'h0,        8};
    vecs[3] = '{1'b1, 32'h24, 32'hCAFEF00D, 0, 32'h0,        1'b1, 32'h0,        8};
    vecs[4] = '{1'b0, 32'h30, 32'h0,        1, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1};
    vecs[5] = '{1'b0, 32'h34, 32'h0,        8, 32'h11112222, 1'b0, 32'h11112222, 8};
    vecs[6] = '{1'b1, 32'h38, 32'h0BADF00D, 2, 32'hFFFFFFFF, 1'b0, 32'h0,        2};

    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_enables", {mem_read_enable, mem_write_enable, mem_data_oe}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // FIFO fills behind one in-flight read; the fifth push is refused.
    push(1'b0, 32'h100, 32'h0);
    tick();
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      req_addr = 32'h100 + 32'(i * 4);
      if (i <= 4) check($sformatf("full_ready_%0d", i), req_ready, 1);
      else begin
        check("full_ready_low", req_ready, 0);
        check("full_count", fifo_count, 4);
      end
      tick();
    end
    req_valid = 1'b0;
    serve_read("full_r0", 32'h100, 32'hA000);
    check("full_still_blocked", req_ready, 0);
    tick();
    check("full_ready_back", req_ready, 1);
    check("full_count_after_pop", fifo_count, 3);
    for (int i = 1; i <= 4; i++)
      serve_read($sformatf("full_r%0d", i), 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
    repeat (3) tick();
    check("full_drained", fifo_count, 0);
    check("full_no_extra_issue", en(), 0);

    // Response back-pressure holds the response and blocks the next issue.
    push(1'b0, 32'h200, 32'h0);
    push(1'b0, 32'h204, 32'h0);
    check("bp_issue", mem_read_enable, 1);
    mem_done = 1'b1;
    mem_data_in = 32'h5555AAAA;
    tick();
    mem_done = 1'b0;
    mem_data_in = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), resp_valid, 1);
      check($sformatf("bp_rdata_%0d", i), resp_rdata, 32'h5555AAAA);
      check($sformatf("bp_no_issue_%0d", i), en(), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_valid_cleared", resp_valid, 0);
    check("bp_idle_gap", en(), 0);
    serve_read("bp_next", 32'h204, 32'h77778888);

    // Asynchronous reset while a write is in flight with two queued.
    push(1'b1, 32'h300, 32'h12121212);
    push(1'b0, 32'h304, 32'h0);
    push(1'b0, 32'h308, 32'h0);
    check("arst_pre_wr", mem_write_enable, 1);
    check("arst_pre_oe", mem_data_oe, 1);
    check("arst_pre_count", fifo_count, 2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_enables", {mem_read_enable, mem_write_enable}, 0);
    check("arst_oe", mem_data_oe, 0);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ready", req_ready, 1);
    #3;
    reset = 1'b1;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    repeat (3) tick();
    check("arst_stray_done_enables", en(), 0);
    check("arst_stray_done_resp", resp_valid, 0);
    check("arst_stray_done_count", fifo_count, 0);

    // Randomized traffic against a memory/queue reference model.
    foreach (mem_model[i]) mem_model[i] = $urandom;
    sent = 0;
    served = 0;
    received = 0;
    fork
      begin : producer
        for (int c = 0; c < 6000 && sent < NRAND; c++) begin
          req_valid = ($urandom_range(0, 1) == 1);
          req_write = 1'($urandom_range(0, 1));
          req_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          req_wdata = $urandom;
          if (req_valid && req_ready) begin
            exp_req.push_back(req_t'({req_write, req_addr, req_wdata}));
            sent++;
          end
          tick();
        end
        req_valid = 1'b0;
      end
      begin : responder
        req_t cur;
        logic active;
        logic nodone;
        int   d;
        int   cyc_en;
        active = 1'b0; nodone = 1'b0; d = 0; cyc_en = 0; cur = '0;
        for (int c = 0; c < 6000 && served < NRAND; c++) begin
          mem_done = 1'b0;
          mem_data_in = $urandom;
          if (active && !en()) begin
            check("rand_enable_cycles", cyc_en, nodone ? TMO : d);
            active = 1'b0;
            served++;
          end
          if (!active && en()) begin
            if (exp_req.size() == 0) check("rand_unexpected_issue", 1, 0);
            else begin
              cur = exp_req.pop_front();
              check("rand_issue_write", mem_write_enable, cur.w);
              check("rand_issue_addr", mem_address, cur.a);
              if (cur.w) check("rand_issue_wdata", mem_data_out, cur.d);
              nodone = ($urandom_range(0, 7) == 0);
              d = $urandom_range(1, TMO);
              cyc_en = 0;
              active = 1'b1;
            end
          end
          if (active) begin
            cyc_en++;
            check("rand_oe", mem_data_oe, cur.w);
            check("rand_one_enable", mem_read_enable && mem_write_enable, 0);
            if (!nodone && cyc_en == d) begin
              mem_done = 1'b1;
              if (cur.w) begin
                mem_model[cur.a[5:2]] = cur.d;
                exp_rsp.push_back(rsp_t'({1'b1, 1'b0, 32'h0}));
              end else begin
                mem_data_in = mem_model[cur.a[5:2]];
                exp_rsp.push_back(rsp_t'({1'b0, 1'b0, mem_data_in}));
              end
            end
            if (nodone && cyc_en == TMO) exp_rsp.push_back(rsp_t'({cur.w, 1'b1, 32'h0}));
          end
          tick();
        end
        mem_done = 1'b0;
      end
      begin : consumer
        rsp_t r;
        for (int c = 0; c < 6000 && received < NRAND; c++) begin
          resp_ready = 1'($urandom_range(0, 1));
          if (resp_valid && resp_ready) begin
            if (exp_rsp.size() == 0) check("rand_unexpected_resp", 1, 0);
            else begin
              r = exp_rsp.pop_front();
              check("rand_resp_write", resp_write, r.w);
              check("rand_resp_error", resp_error, r.err);
              check("rand_resp_rdata", resp_rdata, r.rd);
            end
            received++;
          end
          tick();
        end
        resp_ready = 1'b0;
      end
    join
    check("rand_sent", sent, NRAND);
    check("rand_served", served, NRAND);
    check("rand_received", received, NRAND);
    check("rand_resp_queue_empty", exp_rsp.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
